// File: rtl/rom_stream_reader_pkg.sv
//============================================================================
// Module   : rom_stream_reader_pkg
// Purpose  : Shared FSM encodings and default ROM geometry for the reader.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package rom_stream_reader_pkg;

    localparam int c_def_width  = 8;
    localparam int c_def_depth  = 8;
    localparam int c_def_number = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/stream_out_reg.sv
//============================================================================
// Module   : stream_out_reg
// Purpose  : Valid/ready output register; loads a word or holds it under stall.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module stream_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && ready) begin
            // Consumed with nothing behind it: drop valid, data may stay stale.
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rom_stream_reader.sv
//============================================================================
// Module   : rom_stream_reader
// Purpose  : Walks a wrapping run of ROM addresses and streams the words out
//            on valid/ready with a last flag and a running checksum.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int WIDTH  = c_def_width,
    parameter int DEPTH  = c_def_depth,
    parameter int NUMBER = c_def_number
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUMBER-1:0] start_addr,
    input  logic [NUMBER:0]   start_len,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  checksum,
    output logic              rom_read,
    output logic [NUMBER-1:0] rom_addr,
    input  logic [WIDTH-1:0]  rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_last
);

    localparam logic [NUMBER-1:0] c_last_addr = NUMBER'(DEPTH - 1);
    localparam logic [NUMBER:0]   c_len_one   = (NUMBER + 1)'(1);

    state_t              r_state;
    state_t              w_next_state;
    logic [NUMBER-1:0]   r_cur_addr;
    logic [NUMBER:0]     r_remaining;
    logic [WIDTH-1:0]    r_checksum;
    logic                w_accept;
    logic                w_load;
    logic                w_hs;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_hs     = m_valid && m_ready;
    // ROM is combinational, so a word can be captured in the cycle it is addressed.
    assign w_load   = (r_state == ST_READ) && (r_remaining != '0) && (!m_valid || m_ready);

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        rom_read     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (start_len != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                busy     = 1'b1;
                rom_read = 1'b1;
                if (w_hs && m_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_checksum  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cur_addr  <= start_addr;
                r_remaining <= start_len;
                r_checksum  <= '0;
            end else begin
                if (w_load) begin
                    r_remaining <= r_remaining - 1'b1;
                    r_cur_addr  <= (r_cur_addr == c_last_addr) ? '0 : r_cur_addr + 1'b1;
                end
                if (w_hs) begin
                    r_checksum <= r_checksum + m_data;
                end
            end
        end
    end

    assign rom_addr = r_cur_addr;
    assign checksum = r_checksum;

    stream_out_reg #(
        .WIDTH (WIDTH)
    ) u_stream_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .ready     (m_ready),
        .load_data (rom_data),
        .load_last (r_remaining == c_len_one),
        .valid     (m_valid),
        .data      (m_data),
        .last      (m_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
//============================================================================
// Module   : tb_rom_stream_reader
// Purpose  : Self-checking bench for rom_stream_reader with a ROM holding k+1.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] start_addr;
    logic [3:0] start_len;
    logic       busy;
    logic       done;
    logic [7:0] checksum;
    logic       rom_read;
    logic [2:0] rom_addr;
    logic [7:0] rom_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    logic [7:0] rom_mem [0:7];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Outside a read the ROM bus floats; drive junk so ignoring it is exercised.
    assign rom_data = rom_read ? rom_mem[rom_addr] : 8'hA5;

    rom_stream_reader #(
        .WIDTH  (8),
        .DEPTH  (8),
        .NUMBER (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .start_len  (start_len),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .rom_read   (rom_read),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    typedef struct {
        int addr;
        int len;
        int mode;      // 0 always ready, 1 random ready, 2 stalled until cycle 5
        bit inject;    // extra start pulse with other addr/len in cycle 3
        int exp_sum;
        int exp_done;  // cycle of the done pulse, -1 when not fixed
    } vec_t;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic int exp_word(input int a, input int i);
        return ((a + i) % 8) + 1;
    endfunction

    // One run: start in cycle 0, compare every handshake against the model
    // sequence, then check done timing, checksum and return to idle.
    task automatic run_case(input int addr, input int len, input int mode,
                            input bit inject, input int exp_sum, input int exp_done);
        int   idx       = 0;
        int   model_sum = 0;
        int   want_sum;
        bit   got_done  = 0;
        bit   stalled   = 0;
        logic [7:0] held_data = '0;
        logic       held_last = 1'b0;
        logic [2:0] held_addr = '0;
        for (int i = 0; i < len; i++) model_sum += exp_word(addr, i);
        model_sum = model_sum % 256;
        want_sum  = (exp_sum >= 0) ? exp_sum : model_sum;

        for (int c = 0; c < 200 && !got_done; c++) begin
            start      = (c == 0) || (inject && c == 3);
            start_addr = (c == 0) ? 3'(addr) : 3'(addr + 3);
            start_len  = (c == 0) ? 4'(len) : 4'd7;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = (c >= 5);
            endcase

            if (stalled) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, held_data);
                chk("hold_last", m_last, held_last);
                chk("hold_addr", rom_addr, held_addr);
            end
            if (c == 1) begin
                chk("busy_c1", busy, 1);
                chk("rom_read_c1", rom_read, (len != 0) ? 1 : 0);
            end
            if (c == 2 && mode != 1) chk("first_valid_c2", m_valid, (len != 0) ? 1 : 0);
            if (len == 0) chk("no_valid", m_valid, 0);

            if (m_valid && m_ready) begin
                if (idx < len) begin
                    chk("word", m_data, exp_word(addr, idx) % 256);
                    chk("last", m_last, (idx == len - 1) ? 1 : 0);
                end else begin
                    chk("extra_word", idx, len - 1);
                end
                idx++;
            end
            stalled   = m_valid && !m_ready;
            held_data = m_data;
            held_last = m_last;
            held_addr = rom_addr;

            if (done) begin
                got_done = 1;
                if (exp_done >= 0) chk("done_cycle", c, exp_done);
                chk("word_count", idx, len);
                chk("checksum_done", checksum, want_sum);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!got_done) chk("done_timeout", 0, 1);
        chk("done_pulse_end", done, 0);
        chk("idle_busy", busy, 0);
        chk("checksum_hold", checksum, want_sum);
    endtask

    initial begin
        vec_t vecs [7];
        vecs[0] = '{addr: 0, len: 8,  mode: 0, inject: 0, exp_sum: 36, exp_done: 10};
        vecs[1] = '{addr: 6, len: 4,  mode: 0, inject: 0, exp_sum: 18, exp_done: 6};
        vecs[2] = '{addr: 0, len: 3,  mode: 2, inject: 0, exp_sum: 6,  exp_done: 8};
        vecs[3] = '{addr: 3, len: 0,  mode: 0, inject: 0, exp_sum: 0,  exp_done: 1};
        vecs[4] = '{addr: 2, len: 5,  mode: 0, inject: 1, exp_sum: 25, exp_done: 7};
        vecs[5] = '{addr: 5, len: 15, mode: 0, inject: 0, exp_sum: 67, exp_done: 17};
        vecs[6] = '{addr: 7, len: 1,  mode: 0, inject: 0, exp_sum: 8,  exp_done: 3};

        for (int k = 0; k < 8; k++) rom_mem[k] = 8'(k + 1);
        rst_n = 1'b0; start = 1'b0; start_addr = '0; start_len = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_rom_read", rom_read, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[v]) begin
            run_case(vecs[v].addr, vecs[v].len, vecs[v].mode, vecs[v].inject,
                     vecs[v].exp_sum, vecs[v].exp_done);
        end

        // Asynchronous reset while a word is pending mid-run.
        start = 1'b1; start_addr = 3'd0; start_len = 4'd8; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrun_valid", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_checksum", checksum, 0);
        chk("arst_rom_read", rom_read, 0);
        chk("arst_rom_addr", rom_addr, 0);
        chk("arst_m_data", m_data, 0);
        @(posedge clk); #1;
        chk("arst_no_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_case(0, 8, 0, 0, 36, 10);

        for (int r = 0; r < 25; r++) begin
            run_case($urandom_range(0, 7), $urandom_range(0, 15), 1,
                     1'($urandom_range(0, 1)), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Sequencer directly upstream of the combinational ROM (WIDTH/DEPTH/NUMBER parameterised, read-enable plus address in, data out).
- On a start command it walks a run of ROM addresses, with wrap-around, and drives read/addr.
- It captures each returned word and presents the words on a valid/ready output stream with a last flag.
- It accumulates a modular checksum of the delivered words for the consumer and the test bench.

Parameters:
- WIDTH, 8: ROM word width and m_data/checksum width.
- DEPTH, 8: number of ROM words; legal range 2..2^NUMBER.
- NUMBER, 3: ROM address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command pulse; accepted only in IDLE
- start_addr  in  NUMBER  first ROM address, sampled with start; must be < DEPTH
- start_len  in  NUMBER+1  number of words to read, sampled with start; 0 allowed
- busy  out  1  high in READ and DONE
- done  out  1  one-cycle pulse when the run completes
- checksum  out  WIDTH  sum of delivered words mod 2^WIDTH; held until the next accepted start
- rom_read  out  1  ROM read enable; high only in READ
- rom_addr  out  NUMBER  registered ROM address
- rom_data  in  WIDTH  ROM data_out; sampled only while rom_read=1
- m_valid  out  1  output word valid
- m_ready  in  1  consumer ready
- m_data  out  WIDTH  output word
- m_last  out  1  marks the final word of the run; qualified by m_valid

Behaviour:
- Reset (rst_n=0, asynchronous) drives all registers and outputs to 0, state to IDLE.
  - Reset mid-run abandons the run: no done pulse, m_valid drops immediately, checksum cleared.
- FSM states IDLE, READ, DONE.
- IDLE:
  - start=1 latches cur_addr<=start_addr, remaining<=start_len, checksum<=0.
  - Next state is READ if start_len!=0, otherwise DONE.
  - start in READ or DONE is ignored; no queuing.
- READ:
  - rom_read=1 and rom_addr=cur_addr. Because the ROM is combinational, rom_data is valid in the same cycle.
  - load = (remaining!=0) && (!m_valid || m_ready).
  - On load: m_data<=rom_data, m_valid<=1, m_last<=(remaining==1), remaining<=remaining-1.
  - On load, cur_addr advances: cur_addr<=(cur_addr==DEPTH-1) ? 0 : cur_addr+1.
  - m_valid with m_ready=0: m_data, m_last and m_valid hold stable, and no ROM advance occurs.
  - Handshake (m_valid && m_ready): checksum<=checksum+m_data, truncated to WIDTH bits.
  - Handshake with no new load in the same cycle: m_valid<=0.
  - Handshake with m_last=1: next state is DONE, m_valid<=0, m_last<=0.
- DONE: done=1 for exactly one cycle, then IDLE. checksum is final at the done cycle.
- Throughput: one word per cycle with m_ready held high.
- Latency: start in cycle 0, READ in cycle 1, first m_valid in cycle 2.
- start_len greater than DEPTH is legal: the address wraps repeatedly.
- rom_read=0 outside READ. rom_data is ignored there, since the ROM output is high-Z.
- m_valid never drops without a handshake, except on reset.

Decomposition:
- Shared include file rom_defs.vh:
  - FSM state encodings (IDLE=2'd0, READ=2'd1, DONE=2'd2).
  - Default WIDTH/DEPTH/NUMBER constants, shared with the ROM.
- One natural sub-module, stream_out_reg: the output register holding m_data/m_valid/m_last with load/hold control. All other logic (FSM, address counter, checksum) stays in rom_stream_reader.

Test Plan (bench instantiates the ROM with defaults, contents addr k = k+1, and connects rom_read/rom_addr/rom_data):
- start_addr=0, start_len=8, m_ready=1 -> m_data 1..8 on consecutive cycles from cycle 2; m_last with 8; done at cycle 10; checksum=36.
- start_addr=6, start_len=4 -> wrap: 7,8,1,2; m_last with 2; checksum=18.
- start_addr=0, start_len=3, m_ready=0 for 3 cycles after first valid -> m_data=1 held stable 3 cycles, rom_addr stays 1; then 2,3 delivered; checksum=6.
- start_len=0 -> no m_valid; done pulse in cycle 1; checksum=0; busy high for that one cycle.
- start pulse during READ with different addr/len -> ignored; the original sequence and checksum are unchanged.
- rst_n low while m_valid=1 mid-run -> all outputs 0 asynchronously; after release a new start runs cleanly.
